// File: rtl/inst_buffer_queue_pkg.sv
// inst_buffer_queue_pkg
//   Shared types and sizing for the decode -> rename instruction buffer.
//   renPkt is the packet carried from decode into the rename pipeline register.
package inst_buffer_queue_pkg;

   localparam int DECODE_WIDTH   = 4;
   localparam int DISPATCH_WIDTH = 4;
   localparam int INST_QUEUE     = 32;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
   } renPkt;

   localparam int REN_PKT_SIZE = $bits(renPkt);

endpackage

// File: rtl/inst_buffer_queue_if.sv
// inst_buffer_queue_if
//   Decode-side and rename-side signals of the instruction buffer.
//   master : decode/backend side (drives flush, stall, decode bundle)
//   slave  : the buffer (drives full, ready, head bundle, occupancy)
interface inst_buffer_queue_if #(
   parameter int DEC_W = inst_buffer_queue_pkg::DECODE_WIDTH,
   parameter int DSP_W = inst_buffer_queue_pkg::DISPATCH_WIDTH,
   parameter int CNT_W = $clog2(inst_buffer_queue_pkg::INST_QUEUE) + 1
) ();
   import inst_buffer_queue_pkg::*;

   logic                    flush_i;
   logic                    stall_i;
   logic [DEC_W-1:0]        decValid_i;
   renPkt [DEC_W-1:0]       decPacket_i;
   logic                    instBufferFull_o;
   renPkt [DSP_W-1:0]       renPacket_o;
   logic                    instBufferReady_o;
   logic [CNT_W-1:0]        occupancy_o;

   modport master (
      output flush_i, stall_i, decValid_i, decPacket_i,
      input  instBufferFull_o, renPacket_o, instBufferReady_o, occupancy_o
   );

   modport slave (
      input  flush_i, stall_i, decValid_i, decPacket_i,
      output instBufferFull_o, renPacket_o, instBufferReady_o, occupancy_o
   );

endinterface

// File: rtl/inst_buffer_queue_lane_compact.sv
// ibq_lane_compact
//   Prefix popcount over lane valids. Lane k's write offset is the number of
//   valid lanes below it; nPush_o is the total number of valid lanes.
//   valid_i  : per-lane valid
//   offset_o : per-lane slot offset from the tail
//   nPush_o  : popcount(valid_i)
module ibq_lane_compact #(
   parameter int NLANE = 4,
   parameter int CW    = $clog2(NLANE + 1)
) (
   input  logic [NLANE-1:0]         valid_i,
   output logic [NLANE-1:0][CW-1:0] offset_o,
   output logic [CW-1:0]            nPush_o
);
   import inst_buffer_queue_pkg::*;

   logic [CW-1:0] run;

   always_comb begin
      run      = '0;
      offset_o = '0;
      for (int k = 0; k < NLANE; k++) begin
         offset_o[k] = run;
         run         = run + CW'(valid_i[k]);
      end
      nPush_o = run;
   end

endmodule

// File: rtl/inst_buffer_queue.sv
// inst_buffer_queue
//   Circular buffer between decode and rename. Accepts a whole decode bundle
//   (valid lanes compacted) when at least DECODE_WIDTH slots are free, and
//   releases exactly DISPATCH_WIDTH packets once that many are held.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of inst_buffer_queue_if (flush, stall, decode
//                bundle in; full, ready, head bundle, occupancy out)
module inst_buffer_queue #(
   parameter int DECODE_WIDTH   = inst_buffer_queue_pkg::DECODE_WIDTH,
   parameter int DISPATCH_WIDTH = inst_buffer_queue_pkg::DISPATCH_WIDTH,
   parameter int DEPTH          = inst_buffer_queue_pkg::INST_QUEUE,
   parameter int CNT_W          = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   inst_buffer_queue_if.slave   bus
);
   import inst_buffer_queue_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OFF_W = $clog2(DECODE_WIDTH + 1);

   renPkt             mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [DECODE_WIDTH-1:0][OFF_W-1:0] offset;
   logic [OFF_W-1:0]                   nPush;
   logic                               full, ready, push_en, pop_en;
   logic [CNT_W-1:0]                   free_slots, push_cnt, pop_cnt;

   ibq_lane_compact #(.NLANE(DECODE_WIDTH), .CW(OFF_W)) u_compact (
      .valid_i  (bus.decValid_i),
      .offset_o (offset),
      .nPush_o  (nPush)
   );

   // Full looks only at the registered count, so a pop in the same cycle
   // does not open room; decode simply re-presents next cycle.
   assign free_slots = CNT_W'(DEPTH) - count_q;
   assign full       = free_slots < CNT_W'(DECODE_WIDTH);
   assign ready      = (count_q >= CNT_W'(DISPATCH_WIDTH)) & ~bus.flush_i;
   assign push_en    = ~full & ~bus.flush_i;
   assign pop_en     = ready & ~bus.stall_i;
   assign push_cnt   = push_en ? CNT_W'(nPush) : '0;
   assign pop_cnt    = pop_en ? CNT_W'(DISPATCH_WIDTH) : '0;

   always_comb begin
      head_d  = head_q + (pop_en ? PTR_W'(DISPATCH_WIDTH) : '0);
      tail_d  = tail_q + PTR_W'(push_cnt);
      count_d = count_q + push_cnt - pop_cnt;
      if (bus.flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is not cleared by reset or flush; pointers alone define content.
   // Pointer addition wraps naturally at DEPTH (power of two).
   always_ff @(posedge clk) begin
      if (push_en) begin
         for (int k = 0; k < DECODE_WIDTH; k++) begin
            if (bus.decValid_i[k])
               mem_q[tail_q + PTR_W'(offset[k])] <= bus.decPacket_i[k];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         bus.renPacket_o[i]       = mem_q[head_q + PTR_W'(i)];
         bus.renPacket_o[i].valid = mem_q[head_q + PTR_W'(i)].valid & ready;
      end
   end

   assign bus.instBufferFull_o  = full;
   assign bus.instBufferReady_o = ready;
   assign bus.occupancy_o       = count_q;

   always_ff @(posedge clk) begin
      if (!reset) assert (count_q <= CNT_W'(DEPTH));
   end

endmodule

// File: tb/tb_inst_buffer_queue.sv
module tb_inst_buffer_queue;
   import inst_buffer_queue_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   inst_buffer_queue_if bus ();

   inst_buffer_queue dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   typedef struct {
      logic [3:0] v;
      logic       fl;
      logic       st;
      int         occ;
      logic       rdy;
      logic       full;
   } vec_t;

   vec_t vecs[12];

   function automatic renPkt mk(int id);
      renPkt p;
      p.valid = 1'b1;
      p.pc    = 32'(id);
      p.inst  = 32'hC0DE_0000 ^ 32'(id);
      return p;
   endfunction

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // inputs change at posedge+1, outputs sampled at posedge+2
   task automatic drive(logic [3:0] v, int base, logic fl, logic st);
      bus.decValid_i = v;
      for (int k = 0; k < 4; k++) bus.decPacket_i[k] = mk(base + k);
      bus.flush_i = fl;
      bus.stall_i = st;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(logic [3:0] v, int base);
      for (int k = 0; k < 4; k++) if (v[k]) exp_q.push_back(base + k);
   endtask

   task automatic pop_sb();
      for (int k = 0; k < 4; k++) void'(exp_q.pop_front());
   endtask

   task automatic chk_head(string nm);
      for (int i = 0; i < 4; i++) begin
         int act;
         act = (bus.renPacket_o[i] == mk(exp_q[i])) ? exp_q[i] : -int'(bus.renPacket_o[i].pc) - 1;
         chk($sformatf("%s lane%0d", nm, i), act, exp_q[i]);
      end
   endtask

   function automatic int vbits();
      int r = 0;
      for (int i = 0; i < 4; i++) r |= int'(bus.renPacket_o[i].valid) << i;
      return r;
   endfunction

   initial begin
      vecs[0]  = '{4'b1111, 1'b0, 1'b1, 0, 1'b0, 1'b0};
      vecs[1]  = '{4'b0000, 1'b0, 1'b1, 4, 1'b1, 1'b0};
      vecs[2]  = '{4'b0101, 1'b0, 1'b1, 4, 1'b1, 1'b0};
      vecs[3]  = '{4'b0000, 1'b0, 1'b0, 6, 1'b1, 1'b0};
      vecs[4]  = '{4'b0000, 1'b0, 1'b0, 2, 1'b0, 1'b0};
      vecs[5]  = '{4'b0011, 1'b0, 1'b0, 2, 1'b0, 1'b0};
      vecs[6]  = '{4'b0000, 1'b0, 1'b0, 4, 1'b1, 1'b0};
      vecs[7]  = '{4'b1111, 1'b1, 1'b0, 0, 1'b0, 1'b0};
      vecs[8]  = '{4'b1111, 1'b0, 1'b0, 0, 1'b0, 1'b0};
      vecs[9]  = '{4'b1111, 1'b0, 1'b0, 4, 1'b1, 1'b0};
      vecs[10] = '{4'b0000, 1'b1, 1'b0, 4, 1'b0, 1'b0};
      vecs[11] = '{4'b0000, 1'b0, 1'b0, 0, 1'b0, 1'b0};

      // reset
      reset = 1'b1;
      drive(4'b0000, 0, 1'b0, 1'b0);
      tick(); tick();
      chk("reset occ", int'(bus.occupancy_o), 0);
      chk("reset ready", int'(bus.instBufferReady_o), 0);
      chk("reset full", int'(bus.instBufferFull_o), 0);
      chk("reset valids", vbits(), 0);
      reset = 1'b0;

      // full bundle push, visible next cycle in order
      drive(4'b1111, 0, 1'b0, 1'b1);
      chk("push same-cycle ready", int'(bus.instBufferReady_o), 0);
      tick(); accept(4'b1111, 0);
      drive(4'b0000, 0, 1'b0, 1'b1);
      chk("push1 occ", int'(bus.occupancy_o), 4);
      chk("push1 ready", int'(bus.instBufferReady_o), 1);
      chk_head("push1");
      drive(4'b0000, 0, 1'b0, 1'b0);
      tick(); pop_sb();
      drive(4'b0000, 0, 1'b0, 1'b1);
      chk("pop1 occ", int'(bus.occupancy_o), 0);

      // sparse lanes compacted
      drive(4'b1010, 10, 1'b0, 1'b1); tick(); accept(4'b1010, 10);
      drive(4'b1010, 20, 1'b0, 1'b1); tick(); accept(4'b1010, 20);
      drive(4'b0000, 0, 1'b0, 1'b1);
      chk("sparse occ", int'(bus.occupancy_o), 4);
      chk_head("sparse");
      drive(4'b0000, 0, 1'b1, 1'b1); tick(); exp_q.delete();
      drive(4'b0000, 0, 1'b0, 1'b1);
      chk("flush1 occ", int'(bus.occupancy_o), 0);

      // table: occupancy/ready/full seen in each cycle before its edge
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].v, 100 + 4 * i, vecs[i].fl, vecs[i].st);
         chk($sformatf("vec%0d occ", i), int'(bus.occupancy_o), vecs[i].occ);
         chk($sformatf("vec%0d ready", i), int'(bus.instBufferReady_o), int'(vecs[i].rdy));
         chk($sformatf("vec%0d full", i), int'(bus.instBufferFull_o), int'(vecs[i].full));
         tick();
      end

      // fill under stall until full at 29
      for (int b = 0; b < 7; b++) begin
         drive(4'b1111, 200 + 4 * b, 1'b0, 1'b1);
         chk("fill not full", int'(bus.instBufferFull_o), 0);
         tick(); accept(4'b1111, 200 + 4 * b);
      end
      drive(4'b0001, 228, 1'b0, 1'b1);
      chk("fill 28 full", int'(bus.instBufferFull_o), 0);
      tick(); accept(4'b0001, 228);
      for (int c = 0; c < 3; c++) begin
         drive(4'b1111, 300, 1'b0, 1'b1);
         chk("held occ", int'(bus.occupancy_o), 29);
         chk("held full", int'(bus.instBufferFull_o), 1);
         tick();
      end
      drive(4'b1111, 300, 1'b0, 1'b0);
      chk("unstall ready", int'(bus.instBufferReady_o), 1);
      chk("unstall full", int'(bus.instBufferFull_o), 1);
      chk_head("unstall");
      tick(); pop_sb();
      drive(4'b0000, 0, 1'b0, 1'b1);
      chk("after pop occ", int'(bus.occupancy_o), 25);
      chk("after pop full", int'(bus.instBufferFull_o), 0);
      for (int c = 0; c < 6; c++) begin
         drive(4'b0000, 0, 1'b0, 1'b0);
         chk_head("drain");
         tick(); pop_sb();
      end
      drive(4'b0111, 400, 1'b0, 1'b1); tick(); accept(4'b0111, 400);
      drive(4'b0000, 0, 1'b0, 1'b1);
      chk("refill occ", int'(bus.occupancy_o), 4);
      chk_head("refill");
      drive(4'b0000, 0, 1'b1, 1'b1); tick(); exp_q.delete();

      // steady push4/pop4 with tail offset by 2 so writes straddle the end
      drive(4'b0111, 500, 1'b0, 1'b1); tick(); accept(4'b0111, 500);
      drive(4'b0111, 510, 1'b0, 1'b1); tick(); accept(4'b0111, 510);
      for (int c = 0; c < 20; c++) begin
         drive(4'b1111, 600 + 4 * c, 1'b0, 1'b0);
         chk("steady occ", int'(bus.occupancy_o), 6);
         chk("steady ready", int'(bus.instBufferReady_o), 1);
         chk_head($sformatf("steady%0d", c));
         tick(); pop_sb(); accept(4'b1111, 600 + 4 * c);
      end
      drive(4'b0000, 0, 1'b1, 1'b1); tick(); exp_q.delete();

      // flush with 12 held and a simultaneous push
      for (int b = 0; b < 3; b++) begin
         drive(4'b1111, 700 + 4 * b, 1'b0, 1'b1); tick();
      end
      drive(4'b1111, 720, 1'b1, 1'b0);
      chk("flush12 occ", int'(bus.occupancy_o), 12);
      chk("flush12 ready in flush", int'(bus.instBufferReady_o), 0);
      chk("flush12 valids", vbits(), 0);
      tick();
      drive(4'b0000, 0, 1'b0, 1'b0);
      chk("post flush occ", int'(bus.occupancy_o), 0);
      chk("post flush ready", int'(bus.instBufferReady_o), 0);

      // three held: not ready; one more push enables
      drive(4'b0111, 800, 1'b0, 1'b0); tick(); accept(4'b0111, 800);
      drive(4'b0000, 0, 1'b0, 1'b0);
      chk("occ3", int'(bus.occupancy_o), 3);
      chk("occ3 ready", int'(bus.instBufferReady_o), 0);
      chk("occ3 valids", vbits(), 0);
      drive(4'b0001, 810, 1'b0, 1'b0);
      chk("occ3 push ready", int'(bus.instBufferReady_o), 0);
      tick(); accept(4'b0001, 810);
      drive(4'b0000, 0, 1'b0, 1'b1);
      chk("occ4 ready", int'(bus.instBufferReady_o), 1);
      chk("occ4 occ", int'(bus.occupancy_o), 4);
      chk_head("occ4");

      // reset together with flush and push
      reset = 1'b1;
      drive(4'b1111, 900, 1'b1, 1'b0);
      tick();
      reset = 1'b0;
      drive(4'b0000, 0, 1'b0, 1'b0);
      chk("rst+flush occ", int'(bus.occupancy_o), 0);
      chk("rst+flush ready", int'(bus.instBufferReady_o), 0);
      chk("rst+flush full", int'(bus.instBufferFull_o), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
